// File: rtl/input_fifo_write_arbiter.sv
// Round-robin, burst-locked arbiter sharing the 32-bit input FIFO write port among NUM_REQ word streams.
// Optional per-requester accepted-word counters: define INPUT_ARB_WORD_COUNT_EN.
module input_fifo_write_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int BURST_LEN = 16,
   parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                   ClkxCI,
   input  logic                   RstxRI,
   input  logic [NUM_REQ-1:0]     ReqxSI,
   input  logic [NUM_REQ*32-1:0]  DInxDI,
   input  logic [NUM_REQ-1:0]     LastxSI,
   output logic [NUM_REQ-1:0]     AckxSO,
   output logic [NUM_REQ-1:0]     GntxSO,
   output logic [ID_W-1:0]        OwnerxDO,
   input  logic                   FifoBusyxSI,
   output logic [31:0]            FifoDInxDO,
   output logic                   FifoWExSO,
`ifdef INPUT_ARB_WORD_COUNT_EN
   input  logic                   ClrCntxSI,
   output logic [NUM_REQ*32-1:0]  WordCntxDO,
`endif
   output logic                   StatexDO
);

   // Handshake: word i is transferred in a cycle where AckxSO[i]=1; the requester holds
   // data/last stable while ReqxSI[i]=1 and not acked, and may drop ReqxSI[i] to release.

   typedef enum logic {IDLE, BURST} state_t;

   state_t            StatexDP, StatexDN;
   logic [NUM_REQ-1:0] GntxDP, GntxDN;
   logic [ID_W-1:0]   OwnerxDP, OwnerxDN;
   logic [ID_W-1:0]   RrPtrxDP, RrPtrxDN;
   logic [7:0]        BurstCntxDP, BurstCntxDN;
   logic [31:0]       FifoDataxDP, FifoDataxDN;
   logic              FifoWExDP, FifoWExDN;

   logic              reqOwner, lastOwner, ackOwner, anyReq;
   logic [31:0]       dataOwner;
   logic [7:0]        cntInc;
   logic [ID_W-1:0]   winner;
   int                scanIdx;

   assign reqOwner  = ReqxSI[OwnerxDP];
   assign lastOwner = LastxSI[OwnerxDP];
   assign dataOwner = DInxDI[int'(OwnerxDP)*32 +: 32];
   assign ackOwner  = (StatexDP == BURST) && reqOwner && !FifoBusyxSI;
   assign cntInc    = BurstCntxDP + 8'd1;

   // First requester strictly after the RR pointer, wrapping around.
   always_comb begin
      anyReq  = 1'b0;
      winner  = '0;
      scanIdx = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scanIdx = (int'(RrPtrxDP) + k) % NUM_REQ;
         if (!anyReq && ReqxSI[scanIdx]) begin
            anyReq = 1'b1;
            winner = ID_W'(scanIdx);
         end
      end
   end

   always_comb begin
      StatexDN    = StatexDP;
      GntxDN      = GntxDP;
      OwnerxDN    = OwnerxDP;
      RrPtrxDN    = RrPtrxDP;
      BurstCntxDN = BurstCntxDP;
      FifoDataxDN = FifoDataxDP;
      FifoWExDN   = 1'b0;
      AckxSO      = '0;
      case (StatexDP)
         IDLE: begin
            if (anyReq) begin
               GntxDN      = NUM_REQ'(1) << winner;
               OwnerxDN    = winner;
               BurstCntxDN = '0;
               StatexDN    = BURST;
            end
         end
         BURST: begin
            if (ackOwner) begin
               AckxSO      = GntxDP;
               FifoDataxDN = dataOwner;
               FifoWExDN   = 1'b1;
               BurstCntxDN = cntInc;
            end
            // A dropped request under Busy is a hold; the release is taken once Busy clears.
            if ((ackOwner && (lastOwner || (cntInc == 8'(BURST_LEN)))) ||
                (!reqOwner && !FifoBusyxSI)) begin
               StatexDN = IDLE;
               GntxDN   = '0;
               RrPtrxDN = OwnerxDP;
            end
         end
         default: StatexDN = IDLE;
      endcase
   end

   always_ff @(posedge ClkxCI or posedge RstxRI) begin
      if (RstxRI) begin
         StatexDP    <= IDLE;
         GntxDP      <= '0;
         OwnerxDP    <= '0;
         RrPtrxDP    <= ID_W'(NUM_REQ - 1);
         BurstCntxDP <= '0;
         FifoDataxDP <= '0;
         FifoWExDP   <= 1'b0;
      end else begin
         StatexDP    <= StatexDN;
         GntxDP      <= GntxDN;
         OwnerxDP    <= OwnerxDN;
         RrPtrxDP    <= RrPtrxDN;
         BurstCntxDP <= BurstCntxDN;
         FifoDataxDP <= FifoDataxDN;
         FifoWExDP   <= FifoWExDN;
      end
   end

   assign GntxSO     = GntxDP;
   assign OwnerxDO   = OwnerxDP;
   assign FifoDInxDO = FifoDataxDP;
   assign FifoWExSO  = FifoWExDP;
   assign StatexDO   = (StatexDP == BURST);

`ifdef INPUT_ARB_WORD_COUNT_EN
   logic [31:0] WordCntxDP [NUM_REQ];

   // Clear wins over a same-cycle increment.
   always_ff @(posedge ClkxCI or posedge RstxRI) begin
      if (RstxRI) begin
         for (int i = 0; i < NUM_REQ; i++) WordCntxDP[i] <= '0;
      end else if (ClrCntxSI) begin
         for (int i = 0; i < NUM_REQ; i++) WordCntxDP[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++)
            if (AckxSO[i]) WordCntxDP[i] <= WordCntxDP[i] + 32'd1;
      end
   end

   always_comb begin
      WordCntxDO = '0;
      for (int i = 0; i < NUM_REQ; i++) WordCntxDO[i*32 +: 32] = WordCntxDP[i];
   end
`endif

endmodule

// File: tb/tb_input_fifo_write_arbiter.sv
// Scoreboard bench for input_fifo_write_arbiter (NUM_REQ=2, BURST_LEN=16): expected FIFO writes and
// grant owners are queued by stimulus and retired by negedge monitors.
module tb_input_fifo_write_arbiter;

   logic        ClkxCI = 1'b0;
   logic        RstxRI;
   logic [1:0]  ReqxSI, LastxSI, AckxSO, GntxSO;
   logic [63:0] DInxDI;
   logic [0:0]  OwnerxDO;
   logic        FifoBusyxSI;
   logic [31:0] FifoDInxDO;
   logic        FifoWExSO, StatexDO;
`ifdef INPUT_ARB_WORD_COUNT_EN
   logic        ClrCntxSI;
   logic [63:0] WordCntxDO;
`endif

   logic        reqA  [2];
   logic        lastA [2];
   logic [31:0] dinA  [2];
   int          ackCnt [2];

   logic [31:0] exp_q [$];
   logic [0:0]  gnt_q [$];
   int          checks = 0;
   int          errors = 0;
   bit          dropLat = 1'b0;

   assign ReqxSI  = {reqA[1], reqA[0]};
   assign LastxSI = {lastA[1], lastA[0]};
   assign DInxDI  = {dinA[1], dinA[0]};

   input_fifo_write_arbiter #(.NUM_REQ(2), .BURST_LEN(16)) dut (
      .ClkxCI(ClkxCI), .RstxRI(RstxRI), .ReqxSI(ReqxSI), .DInxDI(DInxDI), .LastxSI(LastxSI),
      .AckxSO(AckxSO), .GntxSO(GntxSO), .OwnerxDO(OwnerxDO), .FifoBusyxSI(FifoBusyxSI),
      .FifoDInxDO(FifoDInxDO), .FifoWExSO(FifoWExSO),
`ifdef INPUT_ARB_WORD_COUNT_EN
      .ClrCntxSI(ClrCntxSI), .WordCntxDO(WordCntxDO),
`endif
      .StatexDO(StatexDO)
   );

   always #5 ClkxCI = ~ClkxCI;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_words(input logic [31:0] base, input int first, input int n);
      for (int i = first; i < first + n; i++) exp_q.push_back(base + 32'(i));
   endtask

   // Presents n words base, base+1, ... on requester r; each word waits (bounded) for its ack.
   task automatic send_block(input int r, input int n, input logic [31:0] base, input bit withLast);
      for (int i = 0; i < n; i++) begin
         int  waitCnt;
         bit  got;
         waitCnt   = 0;
         got       = 1'b0;
         reqA[r]   = 1'b1;
         dinA[r]   = base + 32'(i);
         lastA[r]  = withLast && (i == n - 1);
         while (!got) begin
            @(negedge ClkxCI);
            if (AckxSO[r]) got = 1'b1;
            else waitCnt++;
            @(posedge ClkxCI); #1;
            if (!got && waitCnt > 300) begin
               checks++; errors++;
               $display("FAIL ack_timeout: requester %0d word %0d got no ack, expected ack within 300 cycles", r, i);
               reqA[r] = 1'b0; lastA[r] = 1'b0;
               return;
            end
         end
         ackCnt[r]++;
      end
      reqA[r]  = 1'b0;
      lastA[r] = 1'b0;
   endtask

   task automatic drain(input string name);
      repeat (4) @(posedge ClkxCI);
      #1;
      chk({name, "_exp_q_left"}, 64'(exp_q.size()), 64'd0);
      chk({name, "_gnt_q_left"}, 64'(gnt_q.size()), 64'd0);
   endtask

   task automatic pulse_reset();
      @(posedge ClkxCI); #1;
      RstxRI = 1'b1;
      @(posedge ClkxCI); #1;
      RstxRI = 1'b0;
   endtask

   // Write monitor: data order and ack-to-strobe latency.
   initial begin : write_monitor
      bit prevAck;
      prevAck = 1'b0;
      forever begin
         @(negedge ClkxCI);
         if (dropLat) begin
            prevAck = 1'b0;
         end else begin
            if (prevAck || FifoWExSO) chk("wr_latency", 64'(FifoWExSO), 64'(prevAck));
            if (FifoWExSO) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL wr_unexpected: got write %0h expected no write", FifoDInxDO);
               end else begin
                  chk("wr_data", 64'(FifoDInxDO), 64'(exp_q.pop_front()));
               end
            end
            prevAck = |AckxSO;
         end
      end
   end

   // Grant monitor: each new grant must go to the next queued owner.
   initial begin : grant_monitor
      logic [1:0] prevGnt;
      logic [0:0] e;
      prevGnt = 2'b00;
      forever begin
         @(negedge ClkxCI);
         if (GntxSO != 2'b00 && prevGnt == 2'b00) begin
            if (gnt_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL grant_unexpected: got grant %b expected none", GntxSO);
            end else begin
               e = gnt_q.pop_front();
               chk("grant_owner", 64'(OwnerxDO), 64'(e));
               chk("grant_onehot", 64'(GntxSO), 64'(2'b01 << e));
            end
         end
         prevGnt = GntxSO;
      end
   end

   initial begin : watchdog
      #200000;
      checks++; errors++;
      $display("FAIL watchdog: got no end of test expected end before 200000 ns");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : main
      RstxRI = 1'b1; FifoBusyxSI = 1'b0;
      for (int r = 0; r < 2; r++) begin
         reqA[r] = 1'b0; lastA[r] = 1'b0; dinA[r] = '0; ackCnt[r] = 0;
      end
`ifdef INPUT_ARB_WORD_COUNT_EN
      ClrCntxSI = 1'b0;
`endif
      @(negedge ClkxCI);
      chk("rst_gnt", 64'(GntxSO), 64'd0);
      chk("rst_owner", 64'(OwnerxDO), 64'd0);
      chk("rst_ack", 64'(AckxSO), 64'd0);
      chk("rst_we", 64'(FifoWExSO), 64'd0);
      chk("rst_din", 64'(FifoDInxDO), 64'd0);
      chk("rst_state", 64'(StatexDO), 64'd0);
      @(posedge ClkxCI); #1;
      RstxRI = 1'b0;

      // Single requester, 5 words with Last on the 5th.
      @(posedge ClkxCI); #1;
      gnt_q.push_back(1'b0);
      push_words(32'hA000_0000, 0, 5);
      fork
         send_block(0, 5, 32'hA000_0000, 1'b1);
         begin
            @(negedge ClkxCI);
            chk("a_arb_gnt", 64'(GntxSO), 64'd0);
            chk("a_arb_ack", 64'(AckxSO), 64'd0);
            @(negedge ClkxCI);
            chk("a_gnt", 64'(GntxSO), 64'b01);
            chk("a_state", 64'(StatexDO), 64'd1);
            chk("a_ack", 64'(AckxSO), 64'b01);
         end
      join
      @(negedge ClkxCI);
      chk("a_idle_gnt", 64'(GntxSO), 64'd0);
      drain("a");

      // Both stream 32 words, no Last: bursts of 16 alternate 0,1,0,1.
      pulse_reset();
      @(posedge ClkxCI); #1;
      gnt_q.push_back(1'b0); gnt_q.push_back(1'b1); gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
      push_words(32'hB000_0000, 0, 16);
      push_words(32'hB100_0000, 0, 16);
      push_words(32'hB000_0000, 16, 16);
      push_words(32'hB100_0000, 16, 16);
      fork
         send_block(0, 32, 32'hB000_0000, 1'b0);
         send_block(1, 32, 32'hB100_0000, 1'b0);
      join
      drain("b");

      // Busy for 4 cycles after the third accepted word.
      @(posedge ClkxCI); #1;
      ackCnt[0] = 0;
      gnt_q.push_back(1'b0);
      push_words(32'hC000_0000, 0, 8);
      fork
         send_block(0, 8, 32'hC000_0000, 1'b1);
         begin
            repeat (4) @(posedge ClkxCI);
            #2;
            FifoBusyxSI = 1'b1;
            chk("c_words_before_busy", 64'(ackCnt[0]), 64'd3);
            for (int i = 0; i < 4; i++) begin
               @(negedge ClkxCI);
               chk("c_busy_ack", 64'(AckxSO), 64'd0);
               chk("c_busy_gnt", 64'(GntxSO), 64'b01);
               chk("c_busy_we", 64'(FifoWExSO), 64'(i == 0));
            end
            @(posedge ClkxCI); #2;
            FifoBusyxSI = 1'b0;
         end
      join
      drain("c");

      // Requester 1 releases after 2 words while requester 0 waits.
      @(posedge ClkxCI); #1;
      gnt_q.push_back(1'b1); gnt_q.push_back(1'b0);
      push_words(32'hD100_0000, 0, 2);
      push_words(32'hD000_0000, 0, 2);
      fork
         begin
            send_block(1, 2, 32'hD100_0000, 1'b0);
            @(negedge ClkxCI);
            chk("d_release_gnt", 64'(GntxSO), 64'b10);
            chk("d_release_ack", 64'(AckxSO), 64'd0);
            @(negedge ClkxCI);
            chk("d_idle_gnt", 64'(GntxSO), 64'd0);
            @(negedge ClkxCI);
            chk("d_next_gnt", 64'(GntxSO), 64'b01);
         end
         send_block(0, 2, 32'hD000_0000, 1'b1);
      join
      drain("d");

      // Reset while the first write strobe is high; the in-flight word is dropped.
      @(posedge ClkxCI); #1;
      gnt_q.push_back(1'b0);
      reqA[0] = 1'b1; dinA[0] = 32'hE0E0_0001; lastA[0] = 1'b0;
      @(posedge ClkxCI);
      @(posedge ClkxCI); #1;
      chk("e_pre_we", 64'(FifoWExSO), 64'd1);
      #1;
      dropLat = 1'b1;
      RstxRI  = 1'b1;
      #1;
      chk("e_rst_we", 64'(FifoWExSO), 64'd0);
      chk("e_rst_gnt", 64'(GntxSO), 64'd0);
      chk("e_rst_owner", 64'(OwnerxDO), 64'd0);
      chk("e_rst_ack", 64'(AckxSO), 64'd0);
      chk("e_rst_din", 64'(FifoDInxDO), 64'd0);
      reqA[0] = 1'b0;
      #1;
      RstxRI = 1'b0;
      @(negedge ClkxCI); #1;
      dropLat = 1'b0;
      @(posedge ClkxCI); #1;
      gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
      push_words(32'hE000_0000, 0, 2);
      push_words(32'hE100_0000, 0, 2);
      fork
         send_block(0, 2, 32'hE000_0000, 1'b1);
         send_block(1, 2, 32'hE100_0000, 1'b1);
         begin
            @(negedge ClkxCI);
            @(negedge ClkxCI);
            chk("e_first_gnt", 64'(GntxSO), 64'b01);
         end
      join
      drain("e");

`ifdef INPUT_ARB_WORD_COUNT_EN
      // Word counters: 7 and 3, then a clear coinciding with an ack.
      @(posedge ClkxCI); #1;
      ClrCntxSI = 1'b1;
      @(posedge ClkxCI); #1;
      ClrCntxSI = 1'b0;
      gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
      push_words(32'hF000_0000, 0, 7);
      push_words(32'hF100_0000, 0, 3);
      send_block(0, 7, 32'hF000_0000, 1'b1);
      send_block(1, 3, 32'hF100_0000, 1'b1);
      drain("f");
      chk("f_cnt0", 64'(WordCntxDO[31:0]), 64'd7);
      chk("f_cnt1", 64'(WordCntxDO[63:32]), 64'd3);
      @(posedge ClkxCI); #1;
      ClrCntxSI = 1'b1;
      gnt_q.push_back(1'b0);
      push_words(32'hF200_0000, 0, 1);
      send_block(0, 1, 32'hF200_0000, 1'b1);
      ClrCntxSI = 1'b0;
      drain("g");
      chk("g_cnt0_clr", 64'(WordCntxDO[31:0]), 64'd0);
      chk("g_cnt1_clr", 64'(WordCntxDO[63:32]), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
